// File: rtl/dco_tune_pkg.sv
// Shared encodings for the DCO tuning loop: FSM states, stored error sign, mid-scale helper.
// Latency: none (types and constants only).
// Backpressure: none.
package dco_tune_pkg;

   // FSM encoding is visible on the tune_state output, so the values are fixed.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COARSE = 2'd1,
      ST_FINE   = 2'd2,
      ST_LOCKED = 2'd3
   } tune_state_e;

   // Sign of the last error acted on in COARSE; ZERO means "no history yet".
   typedef enum logic [1:0] {
      SGN_ZERO = 2'd0,
      SGN_POS  = 2'd1,
      SGN_NEG  = 2'd2
   } err_sign_e;

   // Consecutive out-of-range updates that drop LOCKED back to FINE.
   localparam int UnlockCnt = 2;

   // Mid-scale code for a bank of the given width: 2^(width-1).
   function automatic int unsigned mid_scale(input int unsigned width);
      return 32'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/dco_tune_ctrl_if.sv
// Control/status bundle between the frequency-error source and the DCO tuning controller.
// Latency: none (wires only).
// Backpressure: none; err_valid is a fire-and-forget pulse, the controller always accepts it.
interface dco_tune_ctrl_if #(
   parameter int CoarseW = 6,
   parameter int FineW   = 8,
   parameter int ErrW    = 11
);

   logic                      enable;
   logic                      err_valid;
   logic signed [ErrW-1:0]    freq_err;
   logic        [ErrW-2:0]    lock_range;
   logic        [CoarseW-1:0] coarse_code;
   logic        [FineW-1:0]   fine_code;
   logic                      code_update;
   logic                      fll_locked;
   logic        [1:0]         tune_state;

   // Measurement side: drives run control and errors, observes codes and lock.
   modport master (
      output enable, err_valid, freq_err, lock_range,
      input  coarse_code, fine_code, code_update, fll_locked, tune_state
   );

   // Controller side.
   modport slave (
      input  enable, err_valid, freq_err, lock_range,
      output coarse_code, fine_code, code_update, fll_locked, tune_state
   );

endinterface

// File: rtl/dco_lock_det.sv
// Lock hysteresis: counts consecutive in-range updates (FINE) or out-of-range updates (LOCKED).
// Latency: hit outputs are combinational on the qualifying update; count registers on the same edge.
// Backpressure: none; every upd_i is consumed.
module dco_lock_det
   import dco_tune_pkg::*;
#(
   parameter int LockCnt = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic upd_i,
   input  logic in_range_i,
   input  logic locked_i,
   output logic lock_hit_o,
   output logic unlock_hit_o
);

   localparam int CntW = $clog2(LockCnt + UnlockCnt);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;
   logic            streak_evt;

   // One counter serves both directions: while locked it tracks misses, otherwise hits.
   assign streak_evt   = locked_i ? !in_range_i : in_range_i;
   assign lock_hit_o   = upd_i && !locked_i && in_range_i &&
                         (cnt_q == CntW'(LockCnt - 1));
   assign unlock_hit_o = upd_i && locked_i && !in_range_i &&
                         (cnt_q == CntW'(UnlockCnt - 1));

   // Next streak count; any break in the streak or a completed transition restarts it.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (upd_i) begin
         if (lock_hit_o || unlock_hit_o || !streak_evt) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Streak counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dco_tune_ctrl.sv
// DCO coarse/fine capacitor-bank tuning FSM with lock detection; option DCO_TUNE_PROP_STEP_EN adds x4 fine steps.
// Latency: a code change lands on the edge after err_valid, with code_update high for that one cycle.
// Backpressure: none; every err_valid outside IDLE is acted on, enable low overrides everything.
module dco_tune_ctrl
   import dco_tune_pkg::*;
#(
   parameter int CoarseW = 6,
   parameter int FineW   = 8,
   parameter int ErrW    = 11,
   parameter int LockCnt = 4
) (
   input logic            ref_clk,
   input logic            reset,
   dco_tune_ctrl_if.slave tune
);

   localparam logic [CoarseW-1:0] CoarseMid = CoarseW'(mid_scale(CoarseW));
   localparam logic [CoarseW-1:0] CoarseMax = {CoarseW{1'b1}};
   localparam logic [FineW-1:0]   FineMid   = FineW'(mid_scale(FineW));
   localparam logic [FineW-1:0]   FineMax   = {FineW{1'b1}};

   tune_state_e      state_q, state_d;
   err_sign_e        sign_q, sign_d;
   err_sign_e        cur_sign;
   logic [CoarseW-1:0] coarse_q, coarse_d;
   logic [FineW-1:0] fine_q, fine_d;
   logic             code_update_q, code_update_d;

   logic             err_pos;
   logic             err_neg;
   logic             err_zero;
   logic [ErrW:0]    err_ext;
   logic [ErrW:0]    err_abs;
   logic             in_range;
   logic [FineW-1:0] fine_step;
   logic             in_fine_band;
   logic             det_upd;
   logic             det_clr;
   logic             lock_hit;
   logic             unlock_hit;

   // Error classification; magnitude is one bit wider so -2^(ErrW-1) stays positive.
   assign err_neg  = tune.freq_err[ErrW-1];
   assign err_zero = ~|tune.freq_err;
   assign err_pos  = !err_neg && !err_zero;
   assign err_ext  = {tune.freq_err[ErrW-1], tune.freq_err};
   assign err_abs  = err_neg ? (~err_ext + (ErrW+1)'(1)) : err_ext;
   assign in_range = err_abs <= {2'b00, tune.lock_range};
   assign cur_sign = err_pos ? SGN_POS : (err_neg ? SGN_NEG : SGN_ZERO);

`ifdef DCO_TUNE_PROP_STEP_EN
   localparam int PropGain = 4;
   logic big_err;
   // Far outside the window the fine bank moves PropGain LSBs per update.
   assign big_err   = err_abs > {tune.lock_range, 2'b00};
   assign fine_step = big_err ? FineW'(PropGain) : FineW'(1);
`else
   assign fine_step = FineW'(1);
`endif

   // Lock hysteresis only runs while the loop is fine-tuning or locked.
   assign in_fine_band = (state_q == ST_FINE) || (state_q == ST_LOCKED);
   assign det_upd      = tune.enable && tune.err_valid && in_fine_band;
   assign det_clr      = !tune.enable || !in_fine_band;

   dco_lock_det #(
      .LockCnt (LockCnt)
   ) u_lock_det (
      .clk          (ref_clk),
      .rst          (reset),
      .clr_i        (det_clr),
      .upd_i        (det_upd),
      .in_range_i   (in_range),
      .locked_i     (state_q == ST_LOCKED),
      .lock_hit_o   (lock_hit),
      .unlock_hit_o (unlock_hit)
   );

   // Next-state and code update; enable low wins over any measurement in the same cycle.
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      coarse_d = coarse_q;
      fine_d   = fine_q;
      if (!tune.enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // Start each run from fine mid-scale with no sign history.
               state_d = ST_COARSE;
               fine_d  = FineMid;
               sign_d  = SGN_ZERO;
            end
            ST_COARSE: begin
               if (tune.err_valid) begin
                  if (err_zero || (sign_q != SGN_ZERO && cur_sign != sign_q)) begin
                     // Crossed (or hit) the target: hand over to the fine bank as-is.
                     state_d = ST_FINE;
                  end else if (err_pos) begin
                     if (coarse_q != '0) begin
                        coarse_d = coarse_q - CoarseW'(1);
                     end
                  end else begin
                     if (coarse_q != CoarseMax) begin
                        coarse_d = coarse_q + CoarseW'(1);
                     end
                  end
                  sign_d = cur_sign;
               end
            end
            ST_FINE, ST_LOCKED: begin
               if (tune.err_valid) begin
                  if (!in_range) begin
                     if (err_pos) begin
                        if (fine_q == '0) begin
                           // Fine bank exhausted: borrow from coarse unless it is pinned too.
                           if (coarse_q != '0) begin
                              coarse_d = coarse_q - CoarseW'(1);
                              fine_d   = FineMid;
                              state_d  = ST_COARSE;
                              sign_d   = cur_sign;
                           end
                        end else if (fine_q < fine_step) begin
                           fine_d = '0;
                        end else begin
                           fine_d = fine_q - fine_step;
                        end
                     end else begin
                        if (fine_q == FineMax) begin
                           if (coarse_q != CoarseMax) begin
                              coarse_d = coarse_q + CoarseW'(1);
                              fine_d   = FineMid;
                              state_d  = ST_COARSE;
                              sign_d   = cur_sign;
                           end
                        end else if (fine_q > FineMax - fine_step) begin
                           fine_d = FineMax;
                        end else begin
                           fine_d = fine_q + fine_step;
                        end
                     end
                  end
                  // A coarse re-entry takes precedence over lock bookkeeping.
                  if (state_d != ST_COARSE) begin
                     if (state_q == ST_FINE && lock_hit) begin
                        state_d = ST_LOCKED;
                     end else if (state_q == ST_LOCKED && unlock_hit) begin
                        state_d = ST_FINE;
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Pulse whenever either bank actually moves; saturated holds stay silent.
   assign code_update_d = (coarse_d != coarse_q) || (fine_d != fine_q);

   // State, codes and update strobe registers.
   always_ff @(posedge ref_clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         sign_q        <= SGN_ZERO;
         coarse_q      <= CoarseMid;
         fine_q        <= FineMid;
         code_update_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sign_q        <= sign_d;
         coarse_q      <= coarse_d;
         fine_q        <= fine_d;
         code_update_q <= code_update_d;
      end
   end

   assign tune.coarse_code = coarse_q;
   assign tune.fine_code   = fine_q;
   assign tune.code_update = code_update_q;
   assign tune.fll_locked  = (state_q == ST_LOCKED);
   assign tune.tune_state  = state_q;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Bench for dco_tune_ctrl: directed scenarios plus randomized run against an integer reference model.
// Latency: model advances one clock per driven cycle; outputs sampled on the falling edge.
// Backpressure: none.
module tb_dco_tune_ctrl;

   localparam int CW = 6;
   localparam int FW = 8;
   localparam int EW = 11;
   localparam int LC = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int FMAX = (1 << FW) - 1;
   localparam int CMID = 1 << (CW - 1);
   localparam int FMID = 1 << (FW - 1);
   localparam int S_IDLE = 0;
   localparam int S_COARSE = 1;
   localparam int S_FINE = 2;
   localparam int S_LOCKED = 3;

   logic ref_clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   // Reference model state, in plain integers.
   int m_state;
   int m_coarse;
   int m_fine;
   int m_sign;
   int m_cnt;
   int m_upd;

   dco_tune_ctrl_if #(.CoarseW(CW), .FineW(FW), .ErrW(EW)) tune ();

   dco_tune_ctrl #(
      .CoarseW (CW),
      .FineW   (FW),
      .ErrW    (EW),
      .LockCnt (LC)
   ) dut (
      .ref_clk (ref_clk),
      .reset   (reset),
      .tune    (tune)
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
   endtask

   function automatic int sgn(input int v);
      return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic model_reset();
      m_state  = S_IDLE;
      m_coarse = CMID;
      m_fine   = FMID;
      m_sign   = 0;
      m_cnt    = 0;
      m_upd    = 0;
   endtask

   // One clock of the loop's behaviour, written from the rules rather than the datapath.
   task automatic model_step(input bit en, input bit vld, input int err, input int lr);
      int oc, of, mag, dir, stp, inr, was_locked;
      oc = m_coarse;
      of = m_fine;
      mag = (err < 0) ? -err : err;
      dir = -sgn(err);
      if (!en) begin
         m_state = S_IDLE;
         m_cnt   = 0;
      end else if (m_state == S_IDLE) begin
         m_state = S_COARSE;
         m_fine  = FMID;
         m_sign  = 0;
         m_cnt   = 0;
      end else if (vld) begin
         if (m_state == S_COARSE) begin
            if (err == 0 || (m_sign != 0 && sgn(err) != m_sign)) m_state = S_FINE;
            else m_coarse = clamp(m_coarse + dir, 0, CMAX);
            m_sign = sgn(err);
            m_cnt = 0;
         end else begin
            was_locked = (m_state == S_LOCKED);
            inr = (mag <= lr);
            if (!inr) begin
               stp = 1;
`ifdef DCO_TUNE_PROP_STEP_EN
               if (mag > 4 * lr) stp = 4;
`endif
               if ((dir > 0 && m_fine == FMAX) || (dir < 0 && m_fine == 0)) begin
                  if (m_coarse + dir >= 0 && m_coarse + dir <= CMAX) begin
                     m_coarse = m_coarse + dir;
                     m_fine   = FMID;
                     m_state  = S_COARSE;
                     m_sign   = sgn(err);
                     m_cnt    = 0;
                  end
               end else begin
                  m_fine = clamp(m_fine + dir * stp, 0, FMAX);
               end
            end
            if (m_state != S_COARSE) begin
               if (!was_locked) begin
                  m_cnt = inr ? m_cnt + 1 : 0;
                  if (m_cnt == LC) begin m_state = S_LOCKED; m_cnt = 0; end
               end else begin
                  m_cnt = inr ? 0 : m_cnt + 1;
                  if (m_cnt == 2) begin m_state = S_FINE; m_cnt = 0; end
               end
            end
         end
      end
      m_upd = (oc != m_coarse || of != m_fine) ? 1 : 0;
   endtask

   task automatic check_model(input string tag);
      check_eq({tag, "_state"},  int'(tune.tune_state),  m_state);
      check_eq({tag, "_coarse"}, int'(tune.coarse_code), m_coarse);
      check_eq({tag, "_fine"},   int'(tune.fine_code),   m_fine);
      check_eq({tag, "_upd"},    int'(tune.code_update), m_upd);
      check_eq({tag, "_lock"},   int'(tune.fll_locked),  (m_state == S_LOCKED) ? 1 : 0);
   endtask

   // Called on a falling edge: drive, advance model, clock once, compare.
   task automatic drive_step(input bit en, input bit vld, input int err, input int lr, input string tag);
      tune.enable     = en;
      tune.err_valid  = vld;
      tune.freq_err   = err[EW-1:0];
      tune.lock_range = lr[EW-2:0];
      model_step(en, vld, err, lr);
      @(posedge ref_clk);
      @(negedge ref_clk);
      check_model(tag);
   endtask

   task automatic meas(input int err, input int lr, input string tag);
      drive_step(1'b1, 1'b1, err, lr, tag);
      drive_step(1'b1, 1'b0, err, lr, tag);
   endtask

   initial begin
      int exp_f1, exp_f2;
      n_chk = 0;
      n_pass = 0;
      reset = 1'b1;
      tune.enable = 1'b0;
      tune.err_valid = 1'b0;
      tune.freq_err = '0;
      tune.lock_range = '0;
      model_reset();
      repeat (2) @(negedge ref_clk);
      check_model("rst");
      check_eq("rst_coarse", int'(tune.coarse_code), 32);
      check_eq("rst_fine", int'(tune.fine_code), 128);
      reset = 1'b0;

      // Enable starts a run in COARSE at mid-scale.
      drive_step(1'b1, 1'b0, 0, 2, "en");
      check_eq("en_state", int'(tune.tune_state), 1);
      check_eq("en_coarse", int'(tune.coarse_code), 32);
      check_eq("en_fine", int'(tune.fine_code), 128);
      check_eq("en_lock", int'(tune.fll_locked), 0);

      // Coarse search until the error sign reverses.
      meas(50, 2, "c50");
      meas(30, 2, "c30");
      check_eq("c30_coarse", int'(tune.coarse_code), 30);
      drive_step(1'b1, 1'b1, -10, 2, "rev");
      check_eq("rev_coarse", int'(tune.coarse_code), 30);
      check_eq("rev_state", int'(tune.tune_state), 2);
      check_eq("rev_upd", int'(tune.code_update), 0);
      drive_step(1'b1, 1'b0, 0, 2, "rev_idle");

      // Lock after four in-range updates, unlock after two misses.
      for (int i = 0; i < 4; i++) begin
         drive_step(1'b1, 1'b1, 1, 2, "lk");
         check_eq("lk_lock", int'(tune.fll_locked), (i == 3) ? 1 : 0);
         drive_step(1'b1, 1'b0, 1, 2, "lk_idle");
      end
      meas(5, 2, "ul1");
      check_eq("ul1_lock", int'(tune.fll_locked), 1);
      check_eq("ul1_fine", int'(tune.fine_code), 127);
      meas(5, 2, "ul2");
      check_eq("ul2_lock", int'(tune.fll_locked), 0);
      check_eq("ul2_state", int'(tune.tune_state), 2);

      // Ramp fine to full scale, then one more push borrows a coarse LSB.
      for (int i = 0; i < 300 && m_fine != FMAX; i++) meas(-20, 2, "ramp");
      check_eq("ramp_fine", int'(tune.fine_code), 255);
      drive_step(1'b1, 1'b1, -20, 2, "sat");
      check_eq("sat_coarse", int'(tune.coarse_code), 31);
      check_eq("sat_fine", int'(tune.fine_code), 128);
      check_eq("sat_state", int'(tune.tune_state), 1);
      check_eq("sat_upd", int'(tune.code_update), 1);
      drive_step(1'b1, 1'b0, 0, 2, "sat_idle");
      check_eq("sat_upd_off", int'(tune.code_update), 0);

      // Fresh run walks coarse down to zero, where it must hold silently.
      drive_step(1'b0, 1'b0, 0, 2, "off");
      drive_step(1'b1, 1'b0, 0, 2, "on");
      for (int i = 0; i < 40 && m_coarse != 0; i++) meas(40, 2, "dn");
      check_eq("dn_coarse", int'(tune.coarse_code), 0);
      drive_step(1'b1, 1'b1, 40, 2, "floor");
      check_eq("floor_coarse", int'(tune.coarse_code), 0);
      check_eq("floor_upd", int'(tune.code_update), 0);
      check_eq("floor_state", int'(tune.tune_state), 1);

      // Fine step size, then enable falling together with a measurement.
`ifdef DCO_TUNE_PROP_STEP_EN
      exp_f1 = 132;
      exp_f2 = 133;
`else
      exp_f1 = 129;
      exp_f2 = 130;
`endif
      drive_step(1'b0, 1'b0, 0, 2, "off2");
      drive_step(1'b1, 1'b0, 0, 2, "on2");
      meas(0, 2, "zero");
      check_eq("zero_state", int'(tune.tune_state), 2);
      meas(-12, 2, "m12");
      check_eq("m12_fine", int'(tune.fine_code), exp_f1);
      meas(-6, 2, "m6");
      check_eq("m6_fine", int'(tune.fine_code), exp_f2);
      drive_step(1'b0, 1'b1, -20, 2, "fall");
      check_eq("fall_state", int'(tune.tune_state), 0);
      check_eq("fall_fine", int'(tune.fine_code), exp_f2);
      check_eq("fall_upd", int'(tune.code_update), 0);

      // Reset in the middle of a measurement aborts without a pulse.
      drive_step(1'b1, 1'b0, 0, 2, "on3");
      meas(-50, 2, "pre_rst");
      tune.err_valid = 1'b1;
      tune.freq_err = 11'sd50;
      reset = 1'b1;
      model_reset();
      @(posedge ref_clk);
      @(negedge ref_clk);
      check_model("mid_rst");
      check_eq("mid_rst_upd", int'(tune.code_update), 0);
      reset = 1'b0;

      // Randomized segments with a drifting bias to reach saturation and lock often.
      for (int seg = 0; seg < 15; seg++) begin
         int bias, lr;
         bias = int'($urandom_range(0, 60)) - 30;
         lr = int'($urandom_range(0, 6));
         for (int k = 0; k < 200; k++) begin
            int err;
            bit en, vld;
            en = ($urandom_range(0, 99) < 97);
            vld = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
               0: err = -1024;
               1: err = 1023;
               2: err = 0;
               default: err = bias + int'($urandom_range(0, 10)) - 5;
            endcase
            drive_step(en, vld, err, lr, "rnd");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dco_tune_ctrl.md
DCO_TUNE_CTRL -- requirements
Module: dco_tune_ctrl

Interface
REQ-001 SHALL have parameter CoarseW, default 6, coarse capacitor-bank code width.
REQ-002 SHALL have parameter FineW, default 8, fine capacitor-bank code width.
REQ-003 SHALL have parameter ErrW, default 11, signed frequency-error width, equal to the upstream divider count width plus 1.
REQ-004 SHALL have parameter LockCnt, default 4, number of consecutive in-range errors required to declare lock.
REQ-005 SHALL have port ref_clk, input, 1 bit: the single clock for the block.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: tuning run; when low, all codes hold.
REQ-008 SHALL have port err_valid, input, 1 bit: one-cycle pulse marking a new measurement.
REQ-009 SHALL have port freq_err, input, ErrW bits, signed: measured count minus target count; positive means the DCO is fast.
REQ-010 SHALL have port lock_range, input, ErrW-1 bits, unsigned: lock window, applied as |freq_err| <= lock_range.
REQ-011 SHALL have port coarse_code, output, CoarseW bits: coarse bank drive.
REQ-012 SHALL have port fine_code, output, FineW bits: fine bank drive.
REQ-013 SHALL have port code_update, output, 1 bit: one-cycle pulse when either code changes.
REQ-014 SHALL have port fll_locked, output, 1 bit: lock indicator.
REQ-015 SHALL have port tune_state, output, 2 bits: current FSM state.

Function
REQ-016 SHALL implement FSM states IDLE=0, COARSE=1, FINE=2, LOCKED=3.
REQ-017 SHALL transition IDLE->COARSE on enable high, with fine_code preset to mid-scale (2^(FineW-1)).
REQ-018 SHALL return to IDLE from any state within 1 cycle of enable low, holding both codes and clearing fll_locked.
REQ-019 SHALL act only on cycles where err_valid=1 and the block is not in IDLE; err_valid is ignored in IDLE.
REQ-020 SHALL, in COARSE, step coarse_code by -1 if freq_err>0, by +1 if freq_err<0, and hold it if freq_err=0.
REQ-021 SHALL move COARSE->FINE when the error sign reverses relative to the previous update or freq_err=0, without changing coarse_code on that update.
REQ-022 SHALL, in FINE and LOCKED, step fine_code opposite to the sign of freq_err by the fine step (REQ-035) when |freq_err|>lock_range, and hold it otherwise.
REQ-023 SHALL, when fine_code is saturated (0 or all-ones) and the error demands further movement in that direction, step coarse_code one LSB in the required direction, recentre fine_code to mid-scale, and enter COARSE.
REQ-024 SHALL saturate coarse_code at 0 and at all-ones with no wrap-around; a demanded step beyond either limit is a hold with no code_update.
REQ-025 SHALL move FINE->LOCKED after LockCnt consecutive valid updates with |freq_err|<=lock_range.
REQ-026 SHALL move LOCKED->FINE after 2 consecutive valid updates with |freq_err|>lock_range.
REQ-027 SHALL assert fll_locked only in LOCKED.
REQ-028 SHALL apply a code change on the clock edge following err_valid (latency of 1), and assert code_update for exactly that cycle.
REQ-029 SHALL compute |freq_err| with ErrW+1 bits internally so that the most-negative value does not overflow.
REQ-030 SHALL, when err_valid and a falling edge of enable coincide, give priority to enable (go to IDLE with codes unchanged).

Reset
REQ-031 SHALL, on reset, set: coarse_code to mid-scale (2^(CoarseW-1)), fine_code to mid-scale, code_update=0, fll_locked=0, tune_state=IDLE, lock counter=0, stored previous sign=0.
REQ-032 SHALL abort any tuning in progress on a mid-operation reset, with no code_update pulse.

Configuration
REQ-033 SHALL use macro DCO_TUNE_PROP_STEP_EN to control proportional fine stepping.
REQ-034 SHALL, with the macro defined, use a fine step of 4 when |freq_err|>4*lock_range, and a step of 1 otherwise; a step of 4 saturates at the fine limits before REQ-023 applies.
REQ-035 SHALL, without the macro, always use a fine step of 1.

Structure
REQ-036 SHALL place the state enum typedef, state encodings and the mid-scale helper constants in package dco_tune_pkg.
REQ-037 SHALL implement the consecutive-in/out-of-range counting and lock hysteresis in sub-module dco_lock_det.

Verification
REQ-038 SHALL verify: reset, then enable=1 -> tune_state=COARSE, coarse=32, fine=128, fll_locked=0.
REQ-039 SHALL verify: COARSE with freq_err=+50,+30,-10 -> coarse 31, 30, then hold at 30 and state=FINE.
REQ-040 SHALL verify: FINE, lock_range=2, freq_err=+1 four times -> fll_locked=1 after the 4th pulse; then +5 twice -> fll_locked=0, state=FINE.
REQ-041 SHALL verify: fine=255, freq_err=-20 -> coarse+1, fine=128, state=COARSE, code_update=1 for one cycle.
REQ-042 SHALL verify: coarse=0 in COARSE, freq_err=+40 -> coarse stays 0, no code_update.
REQ-043 SHALL verify: with DCO_TUNE_PROP_STEP_EN, lock_range=2, freq_err=-12 -> fine+4; freq_err=-6 -> fine+1; and err_valid coincident with enable falling -> IDLE, codes unchanged.
